// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand forwarding select and load-use stall controller
module forward_unit #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             ex_valid
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // EX slot
  logic             ex_v;
  logic [REG_W-1:0] ex_rd;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_rn;
  logic [REG_W-1:0] ex_rm;
  logic             ex_rm_used;
  logic             ex_memread;

  // MEM slot
  logic             mem_v;
  logic [REG_W-1:0] mem_rd;
  logic             mem_regwrite;

  // WB slot
  logic             wb_v;
  logic [REG_W-1:0] wb_rd;
  logic             wb_regwrite;

  logic             stall_c;

  // A slot can supply src only if it really writes that register and src is not XZR
  function automatic logic fwd_hit(input logic v, input logic rw,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] src);
    return v && rw && (rd == src) && (src != ZR);
  endfunction

  // Load in EX whose result the ID instruction needs; a flush overrides it
  always_comb begin
    stall_c = 1'b0;
    if (id_valid && !flush && ex_v && ex_memread && ex_regwrite && (ex_rd != ZR)) begin
      if ((ex_rd == id_rn) || (id_rm_used && (ex_rd == id_rm))) begin
        stall_c = 1'b1;
      end
    end
  end

  assign stall    = stall_c;
  assign ex_valid = ex_v;

  // Slot advance: reset, then flush, then stall, then normal issue
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v         <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_rn        <= '0;
      ex_rm        <= '0;
      ex_rm_used   <= 1'b0;
      ex_memread   <= 1'b0;
      mem_v        <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_v         <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      wb_v        <= mem_v;
      wb_rd       <= mem_rd;
      wb_regwrite <= mem_regwrite;

      mem_rd <= ex_rd;
      if (flush) begin
        mem_v        <= 1'b0;
        mem_regwrite <= 1'b0;
      end else begin
        mem_v        <= ex_v;
        mem_regwrite <= ex_regwrite;
      end

      if (flush || stall_c || !id_valid) begin
        ex_v        <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rm_used  <= 1'b0;
      end else begin
        ex_v        <= 1'b1;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_rn       <= id_rn;
        ex_rm       <= id_rm;
        ex_rm_used  <= id_rm_used;
        ex_memread  <= id_memread;
      end
    end
  end

  // Operand selects: MEM holds the newer value so it beats WB
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (ex_v) begin
      if (fwd_hit(mem_v, mem_regwrite, mem_rd, ex_rn)) begin
        fwd_a_sel = SEL_MEM;
      end else if (fwd_hit(wb_v, wb_regwrite, wb_rd, ex_rn)) begin
        fwd_a_sel = SEL_WB;
      end
      if (ex_rm_used) begin
        if (fwd_hit(mem_v, mem_regwrite, mem_rd, ex_rm)) begin
          fwd_b_sel = SEL_MEM;
        end else if (fwd_hit(wb_v, wb_regwrite, wb_rd, ex_rm)) begin
          fwd_b_sel = SEL_WB;
        end
      end
    end
  end

endmodule

// File: tb/tb_forward_unit.sv
// tb/tb_forward_unit.sv - directed vector table plus randomized model check of forward_unit
module tb_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_rm_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic       ex_valid;

  int errors = 0;
  int checks = 0;

  forward_unit #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rm_used(id_rm_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, idv;
    bit [4:0] rn, rm;
    bit       rmu;
    bit [4:0] rd;
    bit       rw, mr, fl;
    bit [1:0] ea, eb;
    bit       es, ev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int idv, int rn, int rm, int rmu, int rd, int rw,
                              int mr, int fl, int ea, int eb, int es, int ev);
    vec_t v;
    v.rst = rst[0]; v.idv = idv[0]; v.rn = rn[4:0]; v.rm = rm[4:0]; v.rmu = rmu[0];
    v.rd = rd[4:0]; v.rw = rw[0]; v.mr = mr[0]; v.fl = fl[0];
    v.ea = ea[1:0]; v.eb = eb[1:0]; v.es = es[0]; v.ev = ev[0];
    return v;
  endfunction

  task automatic drain();
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0));
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit idv, input bit [4:0] rn, input bit [4:0] rm,
                       input bit rmu, input bit [4:0] rd, input bit rw, input bit mr,
                       input bit fl);
    reset = rst; id_valid = idv; id_rn = rn; id_rm = rm; id_rm_used = rmu;
    id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  // Behavioural reference: pipeline as an array of instruction records, index 0=EX 1=MEM 2=WB
  typedef struct {
    bit       valid, regwrite, memread, rm_used;
    bit [4:0] rd, rn, rm;
  } ins_t;

  ins_t pipe[3];

  function automatic bit [1:0] model_sel(input bit [4:0] src, input bit used);
    if (!pipe[0].valid || !used || src == 5'd31) return 2'b00;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].valid && pipe[k].regwrite && pipe[k].rd == src)
        return (k == 1) ? 2'b10 : 2'b11;
    end
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    ins_t e;
    e = pipe[0];
    if (!id_valid || flush || !e.valid || !e.memread || !e.regwrite || e.rd == 5'd31) return 1'b0;
    return (e.rd == id_rn) || (id_rm_used && e.rd == id_rm);
  endfunction

  task automatic model_step(input bit st);
    ins_t id, bub;
    bub = '{default: 0};
    id.valid = 1'b1; id.regwrite = id_regwrite; id.memread = id_memread;
    id.rm_used = id_rm_used; id.rd = id_rd; id.rn = id_rn; id.rm = id_rm;
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = bub;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = flush ? bub : pipe[0];
      pipe[0] = (flush || st || !id_valid) ? bub : id;
    end
  endtask

  function automatic bit [4:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // EX/MEM forward
    tbl.push_back(mk(0,1,7,8,1,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,9,1,10,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2,0,0,1));
    drain();
    // MEM/WB forward on operand B
    tbl.push_back(mk(0,1,11,12,1,2,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,13,2,1,14,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,3,0,1));
    drain();
    // MEM beats WB
    tbl.push_back(mk(0,1,11,12,1,2,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,11,12,1,2,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,2,15,1,16,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 2,0,0,1));
    drain();
    // Load-use: one stall cycle, bubble, then WB forward
    tbl.push_back(mk(0,1,17,0,0,3,1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,3,18,1,19,1,0,0, 0,0,1,1));
    tbl.push_back(mk(0,1,3,18,1,19,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3,0,0,1));
    drain();
    // Zero register never forwards or stalls
    tbl.push_back(mk(0,1,20,21,1,31,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,31,31,1,22,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,20,0,0,31,1,1,0, 0,0,0,1));
    tbl.push_back(mk(0,1,31,23,1,24,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    drain();
    // Immediate form ignores rm
    tbl.push_back(mk(0,1,25,0,0,4,1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,26,4,0,27,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    drain();
    // Flush beats stall and drops the load
    tbl.push_back(mk(0,1,28,0,0,5,1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,5,29,1,30,1,0,1, 0,0,0,1));
    tbl.push_back(mk(0,1,5,5,1,8,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    drain();
    // Reset mid-stall with all slots writing X6
    tbl.push_back(mk(0,1,1,2,1,6,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,2,1,6,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,1,2,1,6,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,1,0,0,6,1,1,0, 0,0,0,1));
    tbl.push_back(mk(1,1,6,6,1,7,1,0,0, 0,0,1,1));
    tbl.push_back(mk(0,1,6,6,1,7,1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].idv, tbl[i].rn, tbl[i].rm, tbl[i].rmu,
            tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d fwd_a_sel", i), fwd_a_sel, tbl[i].ea);
      chk($sformatf("vec%0d fwd_b_sel", i), fwd_b_sel, tbl[i].eb);
      chk($sformatf("vec%0d stall", i), stall, tbl[i].es);
      chk($sformatf("vec%0d ex_valid", i), ex_valid, tbl[i].ev);
      @(negedge clk);
    end

    // Randomized phase against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    model_step(1'b0);
    @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      bit st;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            rand_reg(), rand_reg(), ($urandom_range(0, 3) != 0), rand_reg(),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0));
      #1;
      st = model_stall();
      chk($sformatf("rnd%0d fwd_a_sel", c), fwd_a_sel, model_sel(pipe[0].rn, 1'b1));
      chk($sformatf("rnd%0d fwd_b_sel", c), fwd_b_sel, model_sel(pipe[0].rm, pipe[0].rm_used));
      chk($sformatf("rnd%0d stall", c), stall, st);
      chk($sformatf("rnd%0d ex_valid", c), ex_valid, pipe[0].valid);
      model_step(st);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
